// File: rtl/eth_phy_10g_rx_block_lock.sv
// 64b/66b RX block-lock engine: hunts for sync-header alignment by pulsing the SerDes bitslip.
// Optional slip statistics counter (rx_slip_count) is built when BLOCK_LOCK_STATS_EN is defined.
module eth_phy_10g_rx_block_lock #(
    parameter int HDR_WIDTH           = 2,
    parameter int BITSLIP_HIGH_CYCLES = 1,
    parameter int BITSLIP_LOW_CYCLES  = 8,
    parameter int LOCK_CNT            = 64,
    parameter int INVLD_LIMIT         = 16,
    parameter int SLIP_RESET_LIMIT    = 132
) (
    input  logic                 rx_clk,
    input  logic                 rx_rst,
    input  logic [HDR_WIDTH-1:0] serdes_rx_hdr,
    output logic                 serdes_rx_bitslip,
    output logic                 serdes_rx_reset_req,
    output logic                 rx_block_lock
`ifdef BLOCK_LOCK_STATS_EN
    ,
    output logic [15:0]          rx_slip_count
`endif
);

    localparam int SH_W   = $clog2(LOCK_CNT + 1);
    localparam int INV_W  = $clog2(INVLD_LIMIT + 1);
    localparam int SLIP_W = $clog2(SLIP_RESET_LIMIT + 1);
    localparam int PH_W   = $clog2(BITSLIP_HIGH_CYCLES + BITSLIP_LOW_CYCLES + 1);

    localparam logic [SH_W-1:0]   SH_LAST   = SH_W'(LOCK_CNT - 1);
    localparam logic [INV_W-1:0]  INV_LAST  = INV_W'(INVLD_LIMIT - 1);
    localparam logic [SLIP_W-1:0] SLIP_LAST = SLIP_W'(SLIP_RESET_LIMIT - 1);
    localparam logic [PH_W-1:0]   HI_LAST   = PH_W'(BITSLIP_HIGH_CYCLES - 1);
    localparam logic [PH_W-1:0]   LO_LAST   = PH_W'((BITSLIP_LOW_CYCLES > 0) ? BITSLIP_LOW_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_SLIP_HI = 2'd1,
        ST_SLIP_LO = 2'd2,
        ST_LOCKED  = 2'd3
    } state_t;

    function automatic logic hdr_is_valid(input logic [HDR_WIDTH-1:0] hdr);
        return ^hdr;
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SH_W-1:0]     r_sh_cnt;
    logic [SH_W-1:0]     w_sh_cnt_nxt;
    logic [INV_W-1:0]    r_invld_cnt;
    logic [INV_W-1:0]    w_invld_cnt_nxt;
    logic [SLIP_W-1:0]   r_slip_cnt;
    logic [SLIP_W-1:0]   w_slip_cnt_nxt;
    logic [PH_W-1:0]     r_ph_cnt;
    logic [PH_W-1:0]     w_ph_cnt_nxt;
    logic                w_slip_start;
    logic                w_reset_req_nxt;
    logic                w_hdr_valid;
    logic                r_bitslip;
    logic                r_reset_req;
    logic                r_block_lock;

    assign w_hdr_valid = hdr_is_valid(serdes_rx_hdr);

    // Next-state and counter update logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_sh_cnt_nxt    = r_sh_cnt;
        w_invld_cnt_nxt = r_invld_cnt;
        w_slip_cnt_nxt  = r_slip_cnt;
        w_ph_cnt_nxt    = r_ph_cnt;
        w_slip_start    = 1'b0;
        w_reset_req_nxt = 1'b0;

        case (r_state)
            ST_HUNT: begin
                if (!w_hdr_valid) begin
                    w_slip_start = 1'b1;
                    w_sh_cnt_nxt = '0;
                end else if (r_sh_cnt == SH_LAST) begin
                    w_state_nxt    = ST_LOCKED;
                    w_sh_cnt_nxt   = '0;
                    w_slip_cnt_nxt = '0;
                end else begin
                    w_sh_cnt_nxt = r_sh_cnt + SH_W'(1);
                end
            end
            ST_SLIP_HI: begin
                if (r_ph_cnt == HI_LAST) begin
                    w_ph_cnt_nxt = '0;
                    w_state_nxt  = (BITSLIP_LOW_CYCLES == 0) ? ST_HUNT : ST_SLIP_LO;
                end else begin
                    w_ph_cnt_nxt = r_ph_cnt + PH_W'(1);
                end
            end
            ST_SLIP_LO: begin
                if (r_ph_cnt == LO_LAST) begin
                    w_ph_cnt_nxt = '0;
                    w_state_nxt  = ST_HUNT;
                end else begin
                    w_ph_cnt_nxt = r_ph_cnt + PH_W'(1);
                end
            end
            ST_LOCKED: begin
                // Loss of lock takes priority over the end-of-window clear.
                if (!w_hdr_valid && (r_invld_cnt == INV_LAST)) begin
                    w_slip_start    = 1'b1;
                    w_sh_cnt_nxt    = '0;
                    w_invld_cnt_nxt = '0;
                end else if (r_sh_cnt == SH_LAST) begin
                    w_sh_cnt_nxt    = '0;
                    w_invld_cnt_nxt = '0;
                end else begin
                    w_sh_cnt_nxt    = r_sh_cnt + SH_W'(1);
                    w_invld_cnt_nxt = r_invld_cnt + INV_W'(!w_hdr_valid);
                end
            end
            default: begin
                w_state_nxt     = ST_HUNT;
                w_sh_cnt_nxt    = '0;
                w_invld_cnt_nxt = '0;
                w_slip_cnt_nxt  = '0;
                w_ph_cnt_nxt    = '0;
            end
        endcase

        if (w_slip_start) begin
            w_state_nxt  = ST_SLIP_HI;
            w_ph_cnt_nxt = '0;
            if (r_slip_cnt == SLIP_LAST) begin
                w_reset_req_nxt = 1'b1;
                w_slip_cnt_nxt  = '0;
            end else begin
                w_slip_cnt_nxt = r_slip_cnt + SLIP_W'(1);
            end
        end else begin
            w_reset_req_nxt = 1'b0;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            r_state      <= ST_HUNT;
            r_sh_cnt     <= '0;
            r_invld_cnt  <= '0;
            r_slip_cnt   <= '0;
            r_ph_cnt     <= '0;
            r_bitslip    <= 1'b0;
            r_reset_req  <= 1'b0;
            r_block_lock <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sh_cnt     <= w_sh_cnt_nxt;
            r_invld_cnt  <= w_invld_cnt_nxt;
            r_slip_cnt   <= w_slip_cnt_nxt;
            r_ph_cnt     <= w_ph_cnt_nxt;
            r_bitslip    <= (w_state_nxt == ST_SLIP_HI);
            r_reset_req  <= w_reset_req_nxt;
            r_block_lock <= (w_state_nxt == ST_LOCKED);
        end
    end

    assign serdes_rx_bitslip   = r_bitslip;
    assign serdes_rx_reset_req = r_reset_req;
    assign rx_block_lock       = r_block_lock;

`ifdef BLOCK_LOCK_STATS_EN
    logic [15:0] r_slip_total;

    // Lifetime slip counter; survives lock, cleared only by reset.
    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            r_slip_total <= 16'd0;
        end else if (w_slip_start && (r_slip_total != 16'hFFFF)) begin
            r_slip_total <= r_slip_total + 16'd1;
        end
    end

    assign rx_slip_count = r_slip_total;
`endif

endmodule

// File: tb/tb_eth_phy_10g_rx_block_lock.sv
// Scoreboard bench for eth_phy_10g_rx_block_lock: default instance plus a SLIP_RESET_LIMIT=4 instance.
module tb_eth_phy_10g_rx_block_lock;

    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] L1   = 6'b100000;
    localparam logic [5:0] S1   = 6'b010000;
    localparam logic [5:0] S2   = 6'b000010;
    localparam logic [5:0] R2   = 6'b000001;

    logic       clk = 1'b0;
    logic       rst1, rst2;
    logic [1:0] hdr1, hdr2;
    logic       slip1, req1, lock1, slip2, req2, lock2;
`ifdef BLOCK_LOCK_STATS_EN
    logic [15:0] cnt1, cnt2;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [5:0] sb_q[$];

    always #5 clk = ~clk;

    eth_phy_10g_rx_block_lock u_dut (
        .rx_clk              (clk),
        .rx_rst              (rst1),
        .serdes_rx_hdr       (hdr1),
        .serdes_rx_bitslip   (slip1),
        .serdes_rx_reset_req (req1),
        .rx_block_lock       (lock1)
`ifdef BLOCK_LOCK_STATS_EN
        ,
        .rx_slip_count       (cnt1)
`endif
    );

    eth_phy_10g_rx_block_lock #(.SLIP_RESET_LIMIT(4)) u_dut_lim (
        .rx_clk              (clk),
        .rx_rst              (rst2),
        .serdes_rx_hdr       (hdr2),
        .serdes_rx_bitslip   (slip2),
        .serdes_rx_reset_req (req2),
        .rx_block_lock       (lock2)
`ifdef BLOCK_LOCK_STATS_EN
        ,
        .rx_slip_count       (cnt2)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One block per cycle: expected {lock1,slip1,req1,lock2,slip2,req2} after the edge.
    task automatic drive(input string tag, input logic r1, input logic [1:0] h1,
                         input logic r2, input logic [5:0] exp);
        logic [5:0] e;
        rst1 = r1;
        hdr1 = h1;
        rst2 = r2;
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_eq(tag, {26'd0, lock1, slip1, req1, lock2, slip2, req2}, {26'd0, e});
    endtask

    task automatic reset1(input string tag);
        drive(tag, 1'b1, 2'b11, 1'b1, NONE);
    endtask

    task automatic lock_run(input string tag);
        for (int i = 1; i <= 64; i++) begin
            drive(tag, 1'b0, (i % 2 == 1) ? 2'b01 : 2'b10, 1'b1, (i == 64) ? L1 : NONE);
        end
    endtask

    // One SLIP_HI cycle plus eight SLIP_LO cycles, all headers ignored.
    task automatic settle(input string tag);
        for (int i = 0; i < 9; i++) begin
            drive(tag, 1'b0, 2'b11, 1'b1, NONE);
        end
    endtask

    task automatic window(input string tag, input int first_bad, input int n_bad, input logic drop);
        logic done;
        logic bad;
        done = 1'b0;
        for (int pos = 1; pos <= 64; pos++) begin
            if (!done) begin
                bad = (pos >= first_bad) && (pos < first_bad + n_bad);
                if (drop && (pos == first_bad + n_bad - 1)) begin
                    drive(tag, 1'b0, 2'b00, 1'b1, S1);
                    done = 1'b1;
                end else begin
                    drive(tag, 1'b0, bad ? 2'b00 : 2'b10, 1'b1, L1);
                end
            end
        end
    endtask

    initial begin
        rst1 = 1'b1;
        rst2 = 1'b1;
        hdr1 = 2'b11;
        hdr2 = 2'b11;

        reset1("reset");
        reset1("reset");

        lock_run("lock64");

        reset1("reset_hunt");
        drive("slip_hunt", 1'b0, 2'b00, 1'b1, S1);
        settle("slip_ignore");
        lock_run("relock");

        window("win15", 1, 15, 1'b0);
        window("win16", 1, 16, 1'b1);
        settle("drop_settle");
        lock_run("relock2");
        window("last_hdr_drop", 49, 16, 1'b1);
        settle("drop_settle2");
        lock_run("relock3");
        window("win15_end", 50, 15, 1'b0);
        window("win16_next", 1, 16, 1'b1);
        settle("drop_settle3");

        for (int i = 0; i < 30; i++) begin
            drive("partial", 1'b0, 2'b01, 1'b1, NONE);
        end
        drive("partial_slip", 1'b0, 2'b11, 1'b1, S1);
        settle("partial_settle");
        lock_run("partial_relock");

        for (int k = 1; k <= 80; k++) begin
            logic [5:0] e;
            e = NONE;
            if ((k - 1) % 10 == 0) begin
                e = S2;
                if (((k - 1) / 10) % 4 == 3) begin
                    e = S2 | R2;
                end
            end
            drive("reset_req", 1'b1, 2'b11, 1'b0, e);
        end

        reset1("reset_slip_lo");
        drive("slip_lo_a", 1'b0, 2'b00, 1'b1, S1);
        drive("slip_lo_b", 1'b0, 2'b11, 1'b1, NONE);
        drive("slip_lo_c", 1'b0, 2'b11, 1'b1, NONE);
        reset1("reset_in_slip_lo");
`ifdef BLOCK_LOCK_STATS_EN
        check_eq("stats_after_reset", {16'd0, cnt1}, 32'd0);
`endif
        lock_run("lock_after_abort");

        reset1("reset_stats");
        drive("stats_slip", 1'b0, 2'b00, 1'b1, S1);
`ifdef BLOCK_LOCK_STATS_EN
        check_eq("stats_one_slip", {16'd0, cnt1}, 32'd1);
`endif
        settle("stats_settle");
        lock_run("stats_lock");
`ifdef BLOCK_LOCK_STATS_EN
        check_eq("stats_kept_on_lock", {16'd0, cnt1}, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
